vwb_arbiter: RTL and testbench
==============================

Name: vwb_arbiter

Overview:
- Vector writeback stage directly downstream of the vector execution stage; owns the single vector register-file write port.
- Merges the unstallable execution writeback stream with the load-unit writeback stream (valid/ready).
- Execution writes are buffered in a small FIFO; a starvation counter guarantees load progress.
- Reports the ticket of every committed write so the issue logic can release scoreboard entries.

Parameters:
- VECTOR_REGISTERS, 32, number of architectural vector registers; address width is $clog2(VECTOR_REGISTERS).
- VECTOR_LANES, 8, lanes per write.
- DATA_WIDTH, 32, bits per lane.
- VECTOR_TICKET_BITS, 5, ticket width.
- FIFO_DEPTH, 4, execution-write buffer entries; power of 2, at least 2.
- STARVE_LIMIT, 3, consecutive blocked load cycles before load takes priority; at least 1.
- AFULL_LEVEL, 2, free-entry threshold for the almost-full output.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_wr_en  in  VECTOR_LANES  per-lane write enables from the execution stage; no backpressure
- ex_wr_addr  in  $clog2(VECTOR_REGISTERS)  destination register
- ex_wr_data  in  VECTOR_LANES*DATA_WIDTH  lane data
- ex_wr_ticket  in  VECTOR_TICKET_BITS  ticket
- ld_valid  in  1  load writeback valid
- ld_ready  out  1  load writeback accepted this cycle
- ld_wr_en  in  VECTOR_LANES  load per-lane enables
- ld_wr_addr  in  $clog2(VECTOR_REGISTERS)  load destination register
- ld_wr_data  in  VECTOR_LANES*DATA_WIDTH  load data
- ld_wr_ticket  in  VECTOR_TICKET_BITS  load ticket
- rf_wr_valid  out  1  a write is committed this cycle
- rf_wr_en  out  VECTOR_LANES  register-file lane enables
- rf_wr_addr  out  $clog2(VECTOR_REGISTERS)  register-file address
- rf_wr_data  out  VECTOR_LANES*DATA_WIDTH  register-file data
- rf_wr_ticket  out  VECTOR_TICKET_BITS  committed ticket
- wb_afull_o  out  1  free entries <= AFULL_LEVEL; tells issue to stop
- wb_ovf_o  out  1  sticky overflow error
- wb_idle_o  out  1  FIFO empty and no rf write pending

Behaviour:
- Reset (async, active-low):
  - rf_wr_valid=0, rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, rf_wr_ticket=0.
  - ld_ready=0, wb_afull_o=0, wb_ovf_o=0, wb_idle_o=1.
  - FIFO pointers, count and starvation counter cleared; in-flight entries discarded.
  - Reset mid-operation drops all buffered writes.
- FIFO push:
  - Push occurs when |ex_wr_en; all-zero enables push nothing.
  - Entry holds {en, addr, data, ticket}; the pushed entry becomes the head candidate the next cycle (no bypass).
- Arbitration (combinational, per cycle):
  - fifo_ne = count != 0; starved = starve_cnt >= STARVE_LIMIT.
  - grant_ld = ld_valid & (!fifo_ne | starved); ld_ready = grant_ld.
  - pop = fifo_ne & !grant_ld.
- Output register:
  - On pop or grant_ld, the next cycle rf_wr_valid=1 and rf_wr_* equal the selected entry; otherwise rf_wr_valid=0 and rf_wr_en=0 (addr/data/ticket hold).
  - A load with all-zero ld_wr_en is still accepted: rf_wr_valid=1, rf_wr_en=0, ticket reported.
- Latency:
  - Execution write to rf_wr: 2 cycles minimum (push at t, pop at t+1, output at t+2).
  - Load handshake to rf_wr: 1 cycle.
- Starvation counter:
  - +1 each cycle ld_valid & !ld_ready, saturating at STARVE_LIMIT.
  - Cleared on a load handshake or when ld_valid=0.
- Count and boundaries:
  - count' = count + push - pop.
  - Push while full with simultaneous pop is legal and not an overflow.
  - Push while full without pop: entry dropped, wb_ovf_o set; sticky until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Status outputs:
  - wb_afull_o = registered (FIFO_DEPTH - count') <= AFULL_LEVEL.
  - wb_idle_o = (count==0) & !rf_wr_valid.

Test Plan:
- Single execution write: ex_wr_en=0xFF, addr=5, ticket=3, ld_valid=0 at cycle 0 -> rf_wr_valid=1, addr=5, ticket=3, en=0xFF at cycle 2 only.
- Load alone: ld_valid=1, addr=7, ticket=9 with FIFO empty -> ld_ready=1 same cycle; rf_wr addr=7 next cycle.
- Contention with STARVE_LIMIT=3: execution pushes every cycle, ld_valid held high -> ld_ready=0 for 3 cycles, 1 on the 4th; no execution entry lost or reordered.
- Full FIFO (DEPTH=4, load blocked via starvation) plus 5th push with no pop -> wb_ovf_o=1 and stays 1; first 4 tickets commit in order. Full plus push plus pop in the same cycle -> no overflow.
- wb_afull_o: count reaches 2 with DEPTH=4, AFULL=2 -> wb_afull_o=1; drains to 1 -> 0.
- Reset mid-stream with 3 entries buffered -> all outputs at reset values; no rf_wr_valid after release until new traffic.

Source files
------------

// File: rtl/vwb_arbiter.sv
// Vector writeback arbiter: buffers the unstallable execution writes in a FIFO,
// merges them with load writebacks, and drives the single register-file write port.
module vwb_arbiter #(
  parameter int VECTOR_REGISTERS   = 32,
  parameter int VECTOR_LANES       = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int VECTOR_TICKET_BITS = 5,
  parameter int FIFO_DEPTH         = 4,
  parameter int STARVE_LIMIT       = 3,
  parameter int AFULL_LEVEL        = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [VECTOR_LANES-1:0]            ex_wr_en,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] ex_wr_addr,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] ex_wr_data,
  input  logic [VECTOR_TICKET_BITS-1:0]      ex_wr_ticket,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  input  logic [VECTOR_LANES-1:0]            ld_wr_en,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0] ld_wr_addr,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0] ld_wr_data,
  input  logic [VECTOR_TICKET_BITS-1:0]      ld_wr_ticket,
  output logic                               rf_wr_valid,
  output logic [VECTOR_LANES-1:0]            rf_wr_en,
  output logic [$clog2(VECTOR_REGISTERS)-1:0] rf_wr_addr,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0] rf_wr_data,
  output logic [VECTOR_TICKET_BITS-1:0]      rf_wr_ticket,
  output logic                               wb_afull_o,
  output logic                               wb_ovf_o,
  output logic                               wb_idle_o
);

  localparam int AW = $clog2(VECTOR_REGISTERS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [VECTOR_LANES-1:0]            en;
    logic [AW-1:0]                      addr;
    logic [VECTOR_LANES*DATA_WIDTH-1:0] data;
    logic [VECTOR_TICKET_BITS-1:0]      ticket;
  } wb_entry_t;

  wb_entry_t       mem [FIFO_DEPTH];
  wb_entry_t       sel;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [SW-1:0]   starve_cnt;
  logic            push, push_ok, pop, fifo_ne, full, starved, grant_ld, ovf_evt, afull_next;

  assign push     = |ex_wr_en;
  assign fifo_ne  = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign starved  = (starve_cnt >= SW'(STARVE_LIMIT));
  // Gated by rst_n so no load is acknowledged while the stage is held in reset.
  assign grant_ld = rst_n & ld_valid & (~fifo_ne | starved);
  assign ld_ready = grant_ld;
  assign pop      = fifo_ne & ~grant_ld;
  assign push_ok  = push & (~full | pop);
  assign ovf_evt  = push & full & ~pop;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_next = count;
    if (push_ok && !pop)      count_next = count + CW'(1);
    else if (!push_ok && pop) count_next = count - CW'(1);
    afull_next = (FIFO_DEPTH - int'(count_next)) <= AFULL_LEVEL;

    sel = mem[rd_ptr];
    if (grant_ld) begin
      sel.en     = ld_wr_en;
      sel.addr   = ld_wr_addr;
      sel.data   = ld_wr_data;
      sel.ticket = ld_wr_ticket;
    end
  end

  // NOTE: entry storage has no reset; validity is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr].en     <= ex_wr_en;
      mem[wr_ptr].addr   <= ex_wr_addr;
      mem[wr_ptr].data   <= ex_wr_data;
      mem[wr_ptr].ticket <= ex_wr_ticket;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      starve_cnt   <= '0;
      rf_wr_valid  <= 1'b0;
      rf_wr_en     <= '0;
      rf_wr_addr   <= '0;
      rf_wr_data   <= '0;
      rf_wr_ticket <= '0;
      wb_afull_o   <= 1'b0;
      wb_ovf_o     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      wb_afull_o <= afull_next;
      if (ovf_evt) wb_ovf_o <= 1'b1;

      // A blocked load ages toward priority; any handshake or idle load restarts the count.
      if (ld_valid && !grant_ld) begin
        if (!starved) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      if (pop || grant_ld) begin
        rf_wr_valid  <= 1'b1;
        rf_wr_en     <= sel.en;
        rf_wr_addr   <= sel.addr;
        rf_wr_data   <= sel.data;
        rf_wr_ticket <= sel.ticket;
      end else begin
        rf_wr_valid  <= 1'b0;
        rf_wr_en     <= '0;
      end
    end
  end

  assign wb_idle_o = ~fifo_ne & ~rf_wr_valid;

endmodule

// File: tb/tb_vwb_arbiter.sv
// Directed bench for vwb_arbiter: latency, load priority, starvation, overflow,
// almost-full and mid-stream reset, with hand-derived expectations.
module tb_vwb_arbiter;

  localparam int L = 8;
  localparam int D = 32;
  localparam int T = 5;
  localparam int AW = 5;
  localparam logic [T-1:0] LD_TKT = 5'd31;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [L-1:0]     ex_wr_en, ld_wr_en, rf_wr_en;
  logic [AW-1:0]    ex_wr_addr, ld_wr_addr, rf_wr_addr;
  logic [L*D-1:0]   ex_wr_data, ld_wr_data, rf_wr_data;
  logic [T-1:0]     ex_wr_ticket, ld_wr_ticket, rf_wr_ticket;
  logic             ld_valid, ld_ready, rf_wr_valid, wb_afull_o, wb_ovf_o, wb_idle_o;

  int checks = 0;
  int errors = 0;
  logic [T-1:0] log_q[$];
  int ld_commits = 0;

  vwb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_wr_ticket(ex_wr_ticket),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wr_en(ld_wr_en), .ld_wr_addr(ld_wr_addr),
    .ld_wr_data(ld_wr_data), .ld_wr_ticket(ld_wr_ticket),
    .rf_wr_valid(rf_wr_valid), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_ticket(rf_wr_ticket), .wb_afull_o(wb_afull_o), .wb_ovf_o(wb_ovf_o), .wb_idle_o(wb_idle_o)
  );

  always #5 clk = ~clk;

  // Commit log: execution tickets in commit order, load commits counted separately.
  always @(negedge clk) begin
    if (rst_n && rf_wr_valid) begin
      if (rf_wr_ticket == LD_TKT) ld_commits++;
      else log_q.push_back(rf_wr_ticket);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wr_en = '0; ex_wr_addr = '0; ex_wr_data = '0; ex_wr_ticket = '0;
    ld_valid = 1'b0; ld_wr_en = '0; ld_wr_addr = '0; ld_wr_data = '0; ld_wr_ticket = '0;
  endtask

  task automatic drive_ex(input logic [T-1:0] tkt, input logic [AW-1:0] addr);
    ex_wr_en = 8'hFF; ex_wr_addr = addr; ex_wr_ticket = tkt;
    ex_wr_data = {L{27'h0, tkt}};
  endtask

  task automatic drive_ld(input logic [T-1:0] tkt, input logic [AW-1:0] addr, input logic [L-1:0] en);
    ld_valid = 1'b1; ld_wr_en = en; ld_wr_addr = addr; ld_wr_ticket = tkt;
    ld_wr_data = {L{32'hC0DE_0000}};
  endtask

  task automatic check_reset_values(input string name);
    logic [22:0] act, exp;
    act = {rf_wr_valid, rf_wr_en, rf_wr_addr, rf_wr_ticket, ld_ready, wb_afull_o, wb_ovf_o, wb_idle_o};
    exp = {1'b0, 8'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
    checks++;
    if (rf_wr_data !== '0) begin
      errors++;
      $display("FAIL %s data: got %h expected 0", name, rf_wr_data);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_exec();
    drive_ex(5'd3, 5'd5);
    tick();
    idle_inputs();
    checks++;
    if (rf_wr_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid: got %b expected 0", rf_wr_valid); end
    tick();
    checks++;
    if ({rf_wr_valid, rf_wr_en, rf_wr_addr, rf_wr_ticket} !== {1'b1, 8'hFF, 5'd5, 5'd3}) begin
      errors++;
      $display("FAIL single_c2_write: got v=%b en=%h a=%0d t=%0d expected v=1 en=ff a=5 t=3",
               rf_wr_valid, rf_wr_en, rf_wr_addr, rf_wr_ticket);
    end
    checks++;
    if (rf_wr_data !== {L{32'd3}}) begin errors++; $display("FAIL single_data: got %h", rf_wr_data); end
    tick();
    checks++;
    if ({rf_wr_valid, wb_idle_o} !== 2'b01) begin
      errors++; $display("FAIL single_c3_idle: got v=%b idle=%b expected v=0 idle=1", rf_wr_valid, wb_idle_o);
    end
  endtask

  task automatic test_load_alone();
    drive_ld(5'd9, 5'd7, 8'h0F);
    #1;
    checks++;
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %b expected 1", ld_ready); end
    tick();
    drive_ld(5'd4, 5'd2, 8'h00);
    #1;
    checks++;
    if ({rf_wr_valid, rf_wr_en, rf_wr_addr, rf_wr_ticket} !== {1'b1, 8'h0F, 5'd7, 5'd9}) begin
      errors++;
      $display("FAIL load_write: got v=%b en=%h a=%0d t=%0d expected v=1 en=0f a=7 t=9",
               rf_wr_valid, rf_wr_en, rf_wr_addr, rf_wr_ticket);
    end
    checks++;
    if (rf_wr_data !== {L{32'hC0DE_0000}}) begin errors++; $display("FAIL load_data: got %h", rf_wr_data); end
    tick();
    idle_inputs();
    checks++;
    if ({rf_wr_valid, rf_wr_en, rf_wr_ticket} !== {1'b1, 8'h00, 5'd4}) begin
      errors++;
      $display("FAIL load_zero_en: got v=%b en=%h t=%0d expected v=1 en=00 t=4", rf_wr_valid, rf_wr_en, rf_wr_ticket);
    end
    tick();
  endtask

  task automatic test_contention();
    log_q.delete(); ld_commits = 0;
    drive_ex(5'd10, 5'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive_ex(5'(10 + i), 5'd1);
      drive_ld(LD_TKT, 5'd3, 8'hFF);
      #1;
      checks++;
      if (ld_ready !== (i == 4)) begin
        errors++; $display("FAIL contention_ready[%0d]: got %b expected %b", i, ld_ready, (i == 4));
      end
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    checks++;
    if (log_q.size() != 5 || ld_commits != 1) begin
      errors++; $display("FAIL contention_count: got %0d ex / %0d ld expected 5 / 1", log_q.size(), ld_commits);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (log_q[i] !== 5'(10 + i)) begin
          errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", i, log_q[i], 10 + i);
        end
      end
    end
  endtask

  task automatic test_fill_overflow();
    log_q.delete(); ld_commits = 0;
    // Held load gets granted every 4th cycle; each grant+push grows the FIFO by one.
    for (int k = 0; k <= 16; k++) begin
      drive_ex(5'(k), 5'd4);
      drive_ld(LD_TKT, 5'd6, 8'hFF);
      #1;
      checks++;
      if (ld_ready !== (k % 4 == 0)) begin
        errors++; $display("FAIL fill_ready[%0d]: got %b expected %b", k, ld_ready, (k % 4 == 0));
      end
      tick();
      if (k == 0 || k == 4) begin
        checks++;
        if (wb_afull_o !== (k == 4)) begin
          errors++; $display("FAIL afull_fill[%0d]: got %b expected %b", k, wb_afull_o, (k == 4));
        end
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (wb_ovf_o !== (k == 16)) begin
          errors++; $display("FAIL ovf[%0d]: got %b expected %b", k, wb_ovf_o, (k == 16));
        end
      end
    end
    idle_inputs();
    repeat (2) tick();
    checks++;
    if (wb_afull_o !== 1'b1) begin errors++; $display("FAIL afull_drain2: got %b expected 1", wb_afull_o); end
    tick();
    checks++;
    if (wb_afull_o !== 1'b0) begin errors++; $display("FAIL afull_drain1: got %b expected 0", wb_afull_o); end
    repeat (3) tick();
    checks++;
    if ({wb_ovf_o, wb_idle_o} !== 2'b11) begin
      errors++; $display("FAIL ovf_sticky_idle: got ovf=%b idle=%b expected 1 1", wb_ovf_o, wb_idle_o);
    end
    checks++;
    if (log_q.size() != 16 || ld_commits != 5) begin
      errors++; $display("FAIL fill_count: got %0d ex / %0d ld expected 16 / 5", log_q.size(), ld_commits);
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (log_q[i] !== 5'(i)) begin
          errors++; $display("FAIL fill_order[%0d]: got %0d expected %0d", i, log_q[i], i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k <= 8; k++) begin
      drive_ex(5'(k), 5'd8);
      drive_ld(LD_TKT, 5'd6, 8'hFF);
      tick();
    end
    checks++;
    if (wb_idle_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got idle=%b expected 0", wb_idle_o); end
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    idle_inputs();
    tick();
    rst_n = 1'b1;
    log_q.delete(); ld_commits = 0;
    repeat (5) tick();
    checks++;
    if (log_q.size() != 0 || ld_commits != 0 || wb_idle_o !== 1'b1) begin
      errors++; $display("FAIL midreset_quiet: got %0d ex / %0d ld idle=%b expected 0 / 0 idle=1",
                         log_q.size(), ld_commits, wb_idle_o);
    end
    drive_ex(5'd7, 5'd9);
    tick();
    idle_inputs();
    tick();
    checks++;
    if ({rf_wr_valid, rf_wr_addr, rf_wr_ticket} !== {1'b1, 5'd9, 5'd7}) begin
      errors++; $display("FAIL midreset_new: got v=%b a=%0d t=%0d expected v=1 a=9 t=7",
                         rf_wr_valid, rf_wr_addr, rf_wr_ticket);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_exec();
    test_load_alone();
    test_contention();
    test_fill_overflow();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
